// File: rtl/inst_mem_loader_ctrl.sv
// ============================================================================
// inst_mem_loader_ctrl: loads instruction words from a byte stream into
// instruction memory, then sequences run / single-step execution.
// Optional feature macro: LOAD_TIMEOUT_EN (inter-byte load timeout).
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_mem_loader_ctrl #(
  parameter int                  ADDRESS_BITS   = 8,
  parameter int                  DATA_BITS      = 32,
  parameter logic [DATA_BITS-1:0] HALT_WORD     = {DATA_BITS{1'b1}},
  parameter int                  TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_done,
  input  logic [7:0]              rx_data,
  input  logic                    halt,
  output logic                    pipe_enable,
  output logic                    write_inst_mem,
  output logic [ADDRESS_BITS-1:0] inst_mem_addr,
  output logic [DATA_BITS-1:0]    inst_mem_data,
  output logic [ADDRESS_BITS:0]   loaded_words,
  output logic                    busy,
  output logic                    load_error
);

  localparam int                    BYTES    = DATA_BITS / 8;
  localparam int                    IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [ADDRESS_BITS-1:0] ADDR_MAX = {ADDRESS_BITS{1'b1}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [IDX_W-1:0]     byte_idx;
  logic [DATA_BITS-1:0] assembler;
  logic [DATA_BITS-1:0] shifted;
  logic                 timeout;

  // Bytes arrive MSB first, so each new byte shifts in at the bottom.
  assign shifted = (assembler << 8) | DATA_BITS'(rx_data);

`ifdef LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] silence_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      silence_cnt <= '0;
    end else if (state != S_LOAD || rx_done) begin
      silence_cnt <= '0;
    end else begin
      silence_cnt <= silence_cnt + CNT_W'(1);
    end
  end

  assign timeout = (state == S_LOAD) && !rx_done &&
                   (silence_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Feature disabled: LOAD waits indefinitely for the next byte.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_done) begin
          case (rx_data)
            8'h01:   state_nxt = S_LOAD;
            8'h02:   state_nxt = S_RUN;
            8'h03:   state_nxt = S_STEP;
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (timeout) begin
          state_nxt = S_IDLE;
        end else if (rx_done && byte_idx == LAST_IDX) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (inst_mem_data == HALT_WORD || inst_mem_addr == ADDR_MAX) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      S_RUN:   if (halt) state_nxt = S_IDLE;
      S_STEP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_enable    = (state == S_RUN) || (state == S_STEP);
    write_inst_mem = (state == S_WRITE);
    busy           = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_mem_addr <= '0;
      inst_mem_data <= '0;
      loaded_words  <= '0;
      load_error    <= 1'b0;
      byte_idx      <= '0;
      assembler     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_done && rx_data == 8'h01) begin
            inst_mem_addr <= '0;
            loaded_words  <= '0;
            load_error    <= 1'b0;
            byte_idx      <= '0;
            assembler     <= '0;
          end
        end
        S_LOAD: begin
          if (timeout) begin
            load_error <= 1'b1;
            byte_idx   <= '0;
            assembler  <= '0;
          end else if (rx_done) begin
            assembler <= shifted;
            if (byte_idx == LAST_IDX) begin
              inst_mem_data <= shifted;
              byte_idx      <= '0;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          loaded_words <= loaded_words + (ADDRESS_BITS + 1)'(1);
          if (inst_mem_data != HALT_WORD) begin
            if (inst_mem_addr == ADDR_MAX) begin
              load_error <= 1'b1;
            end else begin
              inst_mem_addr <= inst_mem_addr + ADDRESS_BITS'(1);
            end
          end
          // A byte arriving here is the first byte of the next word.
          if (rx_done) begin
            assembler <= shifted;
            byte_idx  <= byte_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/inst_mem_loader_ctrl.md
Name: inst_mem_loader_ctrl

Overview:
Controller that owns the instruction-fetch stage's memory-write and stall controls. Assembles 32-bit instruction words from a byte stream (UART receiver side) and writes them to sequential instruction-memory addresses. Afterwards sequences execution in continuous-run or single-step mode by driving the fetch/pipeline enable. Sits between the UART receiver and the instruction-fetch stage / pipeline top.

Parameters:
ADDRESS_BITS, 8, instruction memory address width
DATA_BITS, 32, instruction word width; must be a multiple of 8
HALT_WORD, 32'hFFFFFFFF, word that terminates a load; it is itself written
TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with LOAD_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx_done  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
halt  in  1  level from the pipeline: HALT instruction retired
pipe_enable  out  1  fetch/pipeline advance enable
write_inst_mem  out  1  instruction-memory write strobe; fetch PC frozen while high
inst_mem_addr  out  ADDRESS_BITS  write address
inst_mem_data  out  DATA_BITS  write data
loaded_words  out  ADDRESS_BITS+1  words written by the last load, 0..256
busy  out  1  high in every state except IDLE
load_error  out  1  sticky; overflow or timeout on the last load, cleared by the next LOAD command

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0. Byte index 0, assembler cleared. Reset mid-load or mid-run aborts immediately; memory contents are not restored.
- States: IDLE, LOAD, WRITE, RUN, STEP.
- IDLE: rx_done with rx_data=8'h01 -> LOAD; clear inst_mem_addr, loaded_words, load_error, byte index. 8'h02 -> RUN. 8'h03 -> STEP. Any other byte is ignored.
- LOAD: each rx_done shifts the byte into the assembler, MSB first: the first byte lands in [31:24]. The 4th byte (index 3) copies the assembled word to inst_mem_data, resets the index, and moves to WRITE.
- WRITE: lasts exactly 1 cycle with write_inst_mem=1 and the address/data stable. On exit, loaded_words += 1.
  - Word == HALT_WORD -> IDLE. Address is not incremented.
  - inst_mem_addr == 2^ADDRESS_BITS-1 and word is not HALT -> load_error=1, IDLE. No wrap; loaded_words = 256.
  - Otherwise inst_mem_addr += 1 and return to LOAD.
  - An rx_done arriving during WRITE is accepted as byte 0 of the next word.
- Write path timing: the 4th byte's rx_done at edge N gives write_inst_mem=1 during cycle N+1, low again after edge N+2.
- pipe_enable is never high while write_inst_mem is high.
- RUN: pipe_enable=1 every cycle. halt sampled high -> pipe_enable=0 from the next edge, then IDLE. rx_done is ignored in RUN.
- STEP: pipe_enable=1 for exactly one cycle, then IDLE. halt is ignored in STEP.
- halt already high when a RUN command arrives: exactly one enable cycle, then IDLE.
- Registered outputs only; no combinational path from inputs to outputs.

Optional Feature:
LOAD_TIMEOUT_EN.
- Defined: a counter clears on every rx_done and on entry to LOAD, and counts in LOAD only. Reaching TIMEOUT_CYCLES sets load_error=1 and returns to IDLE; the partial word is discarded and not written.
- Undefined: no counter; LOAD waits indefinitely.

Test Plan:
1. Reset, then bytes 01, 12,34,56,78, FF,FF,FF,FF -> writes 32'h12345678 @0 and 32'hFFFFFFFF @1. loaded_words=2, load_error=0, busy=0 afterwards.
2. LOAD followed by 256 non-halt words -> 256 single-cycle write pulses at addresses 0..255. load_error=1, loaded_words=256, then IDLE.
3. Byte 02 with halt raised 10 cycles later -> pipe_enable high for exactly those cycles, then 0. State returns to IDLE; write_inst_mem stays 0.
4. Byte 03 three times -> exactly three one-cycle pipe_enable pulses.
5. rst asserted low after 2 bytes of a word -> all outputs 0 immediately. A new LOAD then writes its first word at address 0.
6. (LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=50) LOAD, 2 bytes, then silence -> load_error=1 after 50 cycles. No write pulse; busy=0.
